// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory command port arbiter: FSM encodings and the
// default command word width used by the decoder and its neighbours.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_ISSUE   = 2'b01,
    ARB_RESPOND = 2'b10
  } arb_state_t;

  localparam int CMD_W = 32;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. Returns the first set request
// bit found scanning upward from last+1 (modulo NUM_REQ).
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int GRANT_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] last,
  output logic [GRANT_W-1:0] winner,
  output logic               any_valid
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   rot;
  int                   off;
  int                   idx;

  assign req_dbl   = {req, req};
  assign any_valid = |req;

  // Rotate so bit 0 of rot is requester last+1, then take the lowest set bit.
  always_comb begin
    rot = NUM_REQ'(req_dbl >> (int'(last) + 1));
    off = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) off = j;
    end
    idx = int'(last) + 1 + off;
    if (idx >= NUM_REQ) idx = idx - NUM_REQ;
    winner = GRANT_W'(idx);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of the single memory command port, one
// command in flight. Optional issue timeout enabled by MEM_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = CMD_W,
  parameter  int TIMEOUT = 255,
  localparam int GRANT_W = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_start,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     mem_start,
  output logic [WIDTH-1:0]         mem_data,
  input  logic                     mem_ready,
  output logic [GRANT_W-1:0]       grant_id,
  output logic                     busy,
  output logic                     timeout_err
);

  arb_state_t         state, state_nxt;
  logic [GRANT_W-1:0] last, last_nxt;
  logic [GRANT_W-1:0] grant_nxt;
  logic [WIDTH-1:0]   data_nxt;
  logic               start_nxt;
  logic [NUM_REQ-1:0] ready_nxt;
  logic               busy_nxt;
  logic               terr_nxt;
  logic [GRANT_W-1:0] pick_winner;
  logic               pick_any;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req       (req_start),
    .last      (last),
    .winner    (pick_winner),
    .any_valid (pick_any)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             expired;
  assign expired = (cnt == CNT_W'(TIMEOUT - 1));
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ARB_IDLE;
      last        <= GRANT_W'(NUM_REQ - 1);
      grant_id    <= '0;
      mem_data    <= '0;
      mem_start   <= 1'b0;
      req_ready   <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt         <= '0;
`endif
    end else begin
      state       <= state_nxt;
      last        <= last_nxt;
      grant_id    <= grant_nxt;
      mem_data    <= data_nxt;
      mem_start   <= start_nxt;
      req_ready   <= ready_nxt;
      busy        <= busy_nxt;
      timeout_err <= terr_nxt;
`ifdef MEM_TIMEOUT_EN
      cnt         <= cnt_nxt;
`endif
    end
  end

  // Next state and next registered outputs; req_ready/timeout_err are pulses.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    grant_nxt = grant_id;
    data_nxt  = mem_data;
    start_nxt = mem_start;
    ready_nxt = '0;
    busy_nxt  = busy;
    terr_nxt  = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_nxt   = cnt;
`endif
    unique case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_nxt = pick_winner;
          data_nxt  = req_data[int'(pick_winner)*WIDTH +: WIDTH];
          start_nxt = 1'b1;
          busy_nxt  = 1'b1;
          state_nxt = ARB_ISSUE;
`ifdef MEM_TIMEOUT_EN
          cnt_nxt   = '0;
`endif
        end
      end
      ARB_ISSUE: begin
        if (mem_ready) begin
          start_nxt = 1'b0;
          ready_nxt = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
          last_nxt  = grant_id;
          state_nxt = ARB_RESPOND;
`ifdef MEM_TIMEOUT_EN
        end else if (expired) begin
          start_nxt = 1'b0;
          terr_nxt  = 1'b1;
          ready_nxt = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
          last_nxt  = grant_id;
          state_nxt = ARB_RESPOND;
        end else begin
          cnt_nxt   = cnt + 1'b1;
`endif
        end
      end
      ARB_RESPOND: begin
        busy_nxt  = 1'b0;
        state_nxt = ARB_IDLE;
      end
      default: begin
        start_nxt = 1'b0;
        busy_nxt  = 1'b0;
        state_nxt = ARB_IDLE;
      end
    endcase
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory command port (start_for_memory/ready_for_memory style handshake) between NUM_REQ requesters, such as the instruction decoder, fetch and writeback.
- Uses round-robin arbitration with one command in flight at a time.
- Latches the winner's command word, drives it to memory until memory acknowledges, then returns a one-cycle ready pulse to the winner.
- Sits between the decoder/expansion units and the memory controller.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 32, command word width in bits
- GRANT_W, $clog2(NUM_REQ), width of the grant index (localparam, derived)
- TIMEOUT, 255, maximum ISSUE cycles before abort (used only with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-low reset
- req_start  in  NUM_REQ  per-requester request; held high with req_data stable until the matching req_ready pulse
- req_data  in  NUM_REQ*WIDTH  flat command words; requester i occupies bits [i*WIDTH +: WIDTH]
- req_ready  out  NUM_REQ  one-cycle completion pulse to the granted requester
- mem_start  out  1  command valid to memory
- mem_data  out  WIDTH  latched command word
- mem_ready  in  1  memory accepted the command
- grant_id  out  GRANT_W  index of the current or last granted requester
- busy  out  1  high whenever the state is not IDLE
- timeout_err  out  1  one-cycle abort pulse (tied 0 without MEM_TIMEOUT_EN)

Behaviour:
- Reset and clocking:
  - Reset is decided: reset reset, synchronous, active-low; clock clk.
  - While reset=0: state=IDLE; req_ready=0, mem_start=0, mem_data=0, grant_id=0, busy=0, timeout_err=0; rr pointer last=NUM_REQ-1, so requester 0 wins first.
  - All outputs are registered.
- States: IDLE, ISSUE, RESPOND (2-bit encoding).
- IDLE:
  - If any req_start bit is high, pick the first set bit scanning from last+1 upward, modulo NUM_REQ.
  - Latch grant_id=winner and mem_data=req_data[winner]; set mem_start=1 and busy=1; go to ISSUE.
  - If no bit is set, stay in IDLE.
- ISSUE:
  - mem_start and mem_data are held constant.
  - When mem_ready is sampled high: mem_start=0, req_ready[grant_id]=1, last=grant_id; go to RESPOND.
- RESPOND:
  - req_ready returns to 0; busy=0; go to IDLE. Exactly one req_ready pulse per grant.
  - The next arbitration happens in IDLE, giving a one-cycle bubble that lets the requester drop req_start.
- Latency:
  - req_start sampled at edge 0 -> mem_start high after edge 0.
  - mem_ready sampled at edge k -> req_ready high for the cycle after edge k.
  - Minimum request-to-request period for a single requester: 3 cycles plus memory latency.
- Boundary conditions:
  - mem_ready outside ISSUE is ignored.
  - req_start dropping during ISSUE does not cancel the command; it completes and req_ready still pulses.
  - req_start changes of non-granted requesters during ISSUE have no effect until the next IDLE.
  - If all requesters are active continuously, grants rotate 0,1,2,3,0,... No requester waits more than NUM_REQ-1 grants.
  - Pointer wrap: with last=NUM_REQ-1, the scan starts at 0.
  - Reset in any state abandons the in-flight command with no req_ready pulse, and all outputs return to reset values on the next edge.
  - Simultaneous mem_ready and reset: reset wins.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on entry to ISSUE and increments each ISSUE cycle.
  - When it reaches TIMEOUT without mem_ready: mem_start=0, timeout_err=1 for one cycle, req_ready[grant_id]=1 (the requester is released), last=grant_id, go to RESPOND.
- Not defined: no counter; ISSUE waits indefinitely; timeout_err is tied 0.

Decomposition:
- Shared package mem_arb_pkg: state encodings (ARB_IDLE=2'b00, ARB_ISSUE=2'b01, ARB_RESPOND=2'b10) and the default command width constant, shared with the decoder.
- Sub-module rr_pick:
  - Purely combinational rotate-and-priority-encode.
  - Inputs: req vector and last pointer. Outputs: winner index and any_valid.
  - Also reused by the later bus arbiter.

Test Plan:
- Single requester: req_start[2]=1, req_data[2]=32'h9201_04E0, memory acks after 3 cycles -> mem_start high 1 cycle after the request with mem_data=32'h9201_04E0; req_ready[2] pulses once; grant_id=2.
- All four requesters held active, memory acks immediately -> grant order 0,1,2,3,0; one req_ready pulse each; no overlap; busy low exactly one cycle between grants.
- Requester 1 drops req_start mid-ISSUE -> command still completes and req_ready[1] pulses.
- Reset driven low during ISSUE -> the next cycle shows mem_start=0 and busy=0, no req_ready pulse, and requester 0 wins the next arbitration.
- Stray mem_ready=1 while IDLE with no requests -> no outputs change.
- MEM_TIMEOUT_EN, TIMEOUT=8, memory never acks -> after 8 ISSUE cycles, timeout_err and req_ready pulse once, and arbitration moves to the next requester.
